fuec_rx_stream_48_32: RTL and testbench
=======================================

Name: fuec_rx_stream_48_32

Overview:
- Receive-side streaming wrapper for the 48/32 FUEC code.
- Accepts 48-bit codewords over a valid/ready handshake and decodes them by instantiating the combinational fuec_decoder_48_32.
- Emits corrected 32-bit data plus status, again over valid/ready.
- Keeps saturating error-event counters and a sticky capture of the first uncorrectable syndrome for software scrubbing/telemetry.
- Sits between protected storage/link read-out and the consumer, mirroring fuec_encoder_48_32 on the transmit side.

Parameters:
- CNT_W, 16, width of each error-event counter (must be ≥ 2).

Ports:
- clk  input  1  clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  codeword valid.
- in_ready  output  1  block can accept codeword.
- in_cw  input  48  received codeword.
- out_valid  output  1  decoded word valid.
- out_ready  input  1  consumer accepts word.
- out_data  output  32  corrected data bits.
- out_corrected  output  1  an error was corrected in this word.
- out_uncorrectable  output  1  decoder flagged word uncorrectable; out_data is raw data bits.
- out_syndrome  output  16  syndrome of this word.
- cnt_clr  input  1  synchronous clear of counters and capture.
- cnt_corrected  output  CNT_W  corrected-word count.
- cnt_uncorrectable  output  CNT_W  uncorrectable-word count.
- first_ue_valid  output  1  sticky: an uncorrectable word has been seen since last clear.
- first_ue_syndrome  output  16  syndrome of the first uncorrectable word since last clear.

Behaviour:
- Codeword layout, fixed by the package constants:
  - data at cw[31:0];
  - parity at cw[47:32];
  - out_data = r_fix[31:0] of the decoder.
- Two-stage pipeline:
  - S1 registers in_cw.
  - The decoder is evaluated combinationally on S1.
  - S2 registers r_fix data, corrected, uncorrectable and s.
- Latency: a word accepted in cycle N appears on out_valid in cycle N+2 when out_ready is held high. Throughput is 1 word/cycle.
- Handshake rules:
  - Transfer occurs when valid && ready.
  - S2 advance = !s2_valid || out_ready.
  - S1 advance = !s1_valid || S2 advance.
  - in_ready = S1 advance; it is combinational from out_ready, with no other combinational path.
  - out_valid and out_* are driven only from S2 registers.
  - out_* stay stable while out_valid && !out_ready.
- Data ordering is preserved. No word is dropped or duplicated under any out_ready pattern.
- no_error word: corrected=0, uncorrectable=0, syndrome=0.
- Counters:
  - Update only on output transfer (out_valid && out_ready).
  - cnt_corrected increments when out_corrected=1.
  - cnt_uncorrectable increments when out_uncorrectable=1.
  - Both saturate at 2^CNT_W−1 and never wrap.
- cnt_clr in the same cycle as a counting transfer: the counter loads 1, not 0.
- first_ue capture:
  - On the first uncorrectable output transfer with first_ue_valid=0, set first_ue_valid=1 and latch the syndrome.
  - Later uncorrectable words do not overwrite it.
  - cnt_clr clears first_ue_valid and the syndrome.
  - cnt_clr together with an uncorrectable transfer leaves the capture set with that word's syndrome.
- Reset values: all outputs 0 (in_ready=1 once rst_n deasserted, since the pipeline is empty). s1_valid=0, s2_valid=0.
- Reset mid-operation: in-flight words are discarded, with no partial output. Counters and capture clear.
- X on in_cw while in_valid=0 must not propagate into counters or capture.

Decomposition:
- Package fuec_48_32_pkg holds:
  - N=48, K=32, R=16;
  - DATA_LSB=0, DATA_MSB=31, PAR_LSB=32, PAR_MSB=47;
  - typedefs cw_t [47:0], data_t [31:0], synd_t [15:0].
- Sub-module: reuse the existing fuec_decoder_48_32 unchanged (ports r, s, r_fix, pos_error, no_error, corrected, uncorrectable). pos_error is unused here.
- The pipeline/handshake and counter logic stay in this module.

Test Plan:
- Clean word: in_cw = fuec_encoder_48_32(32'h87654321), out_ready=1.
  → out_data=32'h87654321 after 2 cycles; corrected=0; uncorrectable=0; syndrome=0; counters unchanged.
- Single-bit error: same codeword ^ 48'h2.
  → out_data=32'h87654321, out_corrected=1, cnt_corrected=1, syndrome nonzero and equal to the decoder golden model's value.
- Uncorrectable word: error pattern the golden decoder flags uncorrectable, e.g. ^48'h8000_0000_0001.
  → out_uncorrectable=1, cnt_uncorrectable=1, first_ue_valid=1, first_ue_syndrome equals that syndrome.
  - A second such word with a different syndrome leaves the capture unchanged.
- Backpressure: push 5 distinct words back-to-back with out_ready=0.
  → in_ready drops after 2 accepts.
  - Raise out_ready for random cycles: all 5 words emerge in order, outputs stable while stalled.
- Saturation and clear, CNT_W=4:
  - 17 single-bit-error words → cnt_corrected=15.
  - Then cnt_clr with a concurrent corrected transfer → cnt_corrected=1.
- Reset mid-stream: assert rst_n=0 with both stages full.
  → next cycle out_valid=0, counters=0, first_ue_valid=0.
  - After release, the first new word has latency 2.

Source files
------------

// File: rtl/fuec_48_32_pkg.sv
// Shared constants, types and parity-check columns for the 48/32 FUEC code.
// Data bits sit at cw[31:0] and parity bits at cw[47:32].
package fuec_48_32_pkg;

  localparam int N = 48;
  localparam int K = 32;
  localparam int R = 16;

  localparam int DATA_LSB = 0;
  localparam int DATA_MSB = 31;
  localparam int PAR_LSB  = 32;
  localparam int PAR_MSB  = 47;

  typedef logic [N-1:0] cw_t;
  typedef logic [K-1:0] data_t;
  typedef logic [R-1:0] synd_t;

  // Column i of H.
  // Data bit i (i<16) checks parity bits i and i+1.
  // Data bit 16+j checks parity bits j and j+2.
  // Parity bit j checks only itself.
  // All 48 columns are distinct and nonzero.
  function automatic synd_t col(input int i);
    synd_t one;
    one = synd_t'(1);
    if (i < K / 2)
      return (one << (i % R)) |
             (one << ((i + 1) % R));
    else if (i < K)
      return (one << ((i - 16) % R)) |
             (one << ((i - 14) % R));
    else
      return one << (i - K);
  endfunction

endpackage

// File: rtl/fuec_decoder_48_32.sv
// Combinational 48/32 FUEC decoder: syndrome, error locator, correction.
// Ports: r in, s/r_fix/pos_error/no_error/corrected/uncorrectable out.
module fuec_decoder_48_32
  import fuec_48_32_pkg::*;
(
  input  cw_t   r,
  output synd_t s,
  output cw_t   r_fix,
  output cw_t   pos_error,
  output logic  no_error,
  output logic  corrected,
  output logic  uncorrectable
);

  always_comb begin
    s = '0;
    for (int i = 0; i < N; i++)
      if (r[i]) s = s ^ col(i);
    pos_error = '0;
    for (int i = 0; i < N; i++)
      pos_error[i] = (s == col(i));
  end

  assign no_error      = (s == '0);
  assign corrected     = |pos_error;
  assign uncorrectable = !no_error && !corrected;
  assign r_fix         = r ^ pos_error;

endmodule

// File: rtl/fuec_rx_stream_48_32.sv
// Two-stage valid/ready wrapper around fuec_decoder_48_32 with telemetry.
// Ports: in_* codeword stream, out_* decoded stream, cnt_* and first_ue_*.
module fuec_rx_stream_48_32
  import fuec_48_32_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  cw_t              in_cw,
  output logic             out_valid,
  input  logic             out_ready,
  output data_t            out_data,
  output logic             out_corrected,
  output logic             out_uncorrectable,
  output synd_t            out_syndrome,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] cnt_corrected,
  output logic [CNT_W-1:0] cnt_uncorrectable,
  output logic             first_ue_valid,
  output synd_t            first_ue_syndrome
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic  s1_valid;
  cw_t   s1_cw;
  logic  s2_valid;
  data_t s2_data;
  logic  s2_corr;
  logic  s2_ue;
  synd_t s2_synd;

  synd_t dec_s;
  cw_t   dec_fix;
  cw_t   pos_error_unused;
  logic  no_error_unused;
  logic  dec_corr;
  logic  dec_ue;
  data_t fix_data;
  logic [R-1:0] fix_par_unused;

  logic s1_adv;
  logic s2_adv;
  logic xfer;
  logic inc_c;
  logic inc_u;

  fuec_decoder_48_32 u_dec (
    .r             (s1_cw),
    .s             (dec_s),
    .r_fix         (dec_fix),
    .pos_error     (pos_error_unused),
    .no_error      (no_error_unused),
    .corrected     (dec_corr),
    .uncorrectable (dec_ue)
  );

  assign {fix_par_unused, fix_data} = dec_fix;

  assign s2_adv   = !s2_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  assign xfer  = s2_valid && out_ready;
  assign inc_c = xfer && s2_corr;
  assign inc_u = xfer && s2_ue;

  // Payload loads are gated by valid so idle-bus X never enters state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_cw    <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) s1_cw <= in_cw;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_corr  <= 1'b0;
      s2_ue    <= 1'b0;
      s2_synd  <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_data <= fix_data;
        s2_corr <= dec_corr;
        s2_ue   <= dec_ue;
        s2_synd <= dec_s;
      end
    end
  end

  // A clear coinciding with a counted transfer keeps that one event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_corrected     <= '0;
      cnt_uncorrectable <= '0;
    end else if (cnt_clr) begin
      cnt_corrected     <= CNT_W'(inc_c);
      cnt_uncorrectable <= CNT_W'(inc_u);
    end else begin
      if (inc_c && cnt_corrected != CNT_MAX)
        cnt_corrected <= cnt_corrected + CNT_W'(1);
      if (inc_u && cnt_uncorrectable != CNT_MAX)
        cnt_uncorrectable <= cnt_uncorrectable + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_ue_valid    <= 1'b0;
      first_ue_syndrome <= '0;
    end else if (cnt_clr) begin
      first_ue_valid    <= inc_u;
      first_ue_syndrome <= inc_u ? s2_synd : '0;
    end else if (inc_u && !first_ue_valid) begin
      first_ue_valid    <= 1'b1;
      first_ue_syndrome <= s2_synd;
    end
  end

  assign out_valid         = s2_valid;
  assign out_data          = s2_data;
  assign out_corrected     = s2_corr;
  assign out_uncorrectable = s2_ue;
  assign out_syndrome      = s2_synd;

endmodule

// File: tb/tb_fuec_rx_stream_48_32.sv
// Directed self-checking bench for fuec_rx_stream_48_32 (CNT_W=4).
// Expected codewords and syndromes are hand-computed from the H columns.
module tb_fuec_rx_stream_48_32;
  import fuec_48_32_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  cw_t         in_cw;
  logic        out_valid;
  logic        out_ready;
  data_t       out_data;
  logic        out_corrected;
  logic        out_uncorrectable;
  synd_t       out_syndrome;
  logic        cnt_clr;
  logic [3:0]  cnt_corrected;
  logic [3:0]  cnt_uncorrectable;
  logic        first_ue_valid;
  synd_t       first_ue_syndrome;

  int npass;
  int ntotal;

  // data 87654321 -> parity 5F90
  localparam cw_t BASE = 48'h5F90_8765_4321;
  localparam cw_t E_D1 = 48'h0000_0000_0002;
  localparam cw_t E_P0 = 48'h0001_0000_0000;
  localparam cw_t E_U1 = 48'h8000_0000_0001;
  localparam cw_t E_U2 = 48'h4000_0000_0001;

  fuec_rx_stream_48_32 #(.CNT_W(4)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_cw             (in_cw),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_data          (out_data),
    .out_corrected     (out_corrected),
    .out_uncorrectable (out_uncorrectable),
    .out_syndrome      (out_syndrome),
    .cnt_clr           (cnt_clr),
    .cnt_corrected     (cnt_corrected),
    .cnt_uncorrectable (cnt_uncorrectable),
    .first_ue_valid    (first_ue_valid),
    .first_ue_syndrome (first_ue_syndrome)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input string what,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s.%s observed=%0h expected=%0h",
                tag, what, obs, exp);
  endtask

  task automatic push1(input string tag, input cw_t cw,
                       input data_t d, input logic c,
                       input logic u, input synd_t s);
    @(negedge clk);
    in_valid = 1'b1;
    in_cw    = cw;
    @(negedge clk);
    in_valid = 1'b0;
    in_cw    = 'x;
    chk(tag, "lat1_valid", out_valid, 0);
    @(negedge clk);
    chk(tag, "valid", out_valid, 1);
    chk(tag, "data", out_data, d);
    chk(tag, "corr", out_corrected, c);
    chk(tag, "ue", out_uncorrectable, u);
    chk(tag, "synd", out_syndrome, s);
    @(negedge clk);
  endtask

  task automatic clr_xfer(input cw_t cw);
    @(negedge clk);
    in_valid = 1'b1;
    in_cw    = cw;
    @(negedge clk);
    in_valid = 1'b0;
    in_cw    = 'x;
    @(negedge clk);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
  endtask

  cw_t         bp_w [5];
  data_t       bp_d [5];
  logic [31:0] pat;

  initial begin
    int ii;
    int oi;
    npass     = 0;
    ntotal    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_cw     = '0;
    out_ready = 1'b1;
    cnt_clr   = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst", "out_valid", out_valid, 0);
    chk("rst", "in_ready", in_ready, 1);
    chk("rst", "out_data", out_data, 0);
    chk("rst", "cnt_c", cnt_corrected, 0);
    chk("rst", "cnt_u", cnt_uncorrectable, 0);
    chk("rst", "fue_v", first_ue_valid, 0);
    chk("rst", "fue_s", first_ue_syndrome, 0);

    push1("clean", BASE, 32'h8765_4321, 0, 0, 16'h0000);
    chk("clean", "cnt_c", cnt_corrected, 0);
    chk("clean", "cnt_u", cnt_uncorrectable, 0);

    push1("sbe", BASE ^ E_D1, 32'h8765_4321, 1, 0, 16'h0006);
    chk("sbe", "cnt_c", cnt_corrected, 1);

    push1("ue1", BASE ^ E_U1, 32'h8765_4320, 0, 1, 16'h8003);
    chk("ue1", "cnt_u", cnt_uncorrectable, 1);
    chk("ue1", "fue_v", first_ue_valid, 1);
    chk("ue1", "fue_s", first_ue_syndrome, 16'h8003);

    push1("ue2", BASE ^ E_U2, 32'h8765_4320, 0, 1, 16'h4003);
    chk("ue2", "cnt_u", cnt_uncorrectable, 2);
    chk("ue2", "fue_s", first_ue_syndrome, 16'h8003);

    push1("perr", BASE ^ E_P0, 32'h8765_4321, 1, 0, 16'h0001);
    chk("perr", "cnt_c", cnt_corrected, 2);

    // Clean words: data bit k sets parity from its column.
    bp_w[0] = 48'h0000_0000_0000; bp_d[0] = 32'h0000_0000;
    bp_w[1] = 48'h0003_0000_0001; bp_d[1] = 32'h0000_0001;
    bp_w[2] = 48'h0005_0001_0000; bp_d[2] = 32'h0001_0000;
    bp_w[3] = 48'h8001_0000_8000; bp_d[3] = 32'h0000_8000;
    bp_w[4] = 48'h8002_8000_0000; bp_d[4] = 32'h8000_0000;
    pat = 32'b1111_1111_1111_1111_1111_1110_0110_1000;
    ii = 0;
    oi = 0;
    for (int k = 0; k < 32 && oi < 5; k++) begin
      @(negedge clk);
      out_ready = pat[k];
      in_valid  = (ii < 5);
      in_cw     = (ii < 5) ? bp_w[ii] : 'x;
      #1;
      if (k == 2) begin
        chk("bp", "in_ready_drop", in_ready, 0);
        chk("bp", "accepted", ii, 2);
      end
      if (out_valid) begin
        chk("bp", "data", out_data, bp_d[oi]);
        chk("bp", "synd", out_syndrome, 0);
        if (out_ready) oi++;
      end
      if (in_valid && in_ready) ii++;
    end
    chk("bp", "drained", oi, 5);
    @(negedge clk);
    in_valid  = 1'b0;
    in_cw     = 'x;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("bp", "out_valid_idle", out_valid, 0);
    chk("bp", "cnt_c", cnt_corrected, 2);
    chk("bp", "cnt_u", cnt_uncorrectable, 2);
    chk("bp", "fue_s", first_ue_syndrome, 16'h8003);

    for (int k = 0; k < 17; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_cw    = BASE ^ E_D1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_cw    = 'x;
    repeat (3) @(negedge clk);
    chk("sat", "cnt_c", cnt_corrected, 15);
    chk("sat", "cnt_u", cnt_uncorrectable, 2);

    clr_xfer(BASE ^ E_D1);
    chk("clr_c", "cnt_c", cnt_corrected, 1);
    chk("clr_c", "cnt_u", cnt_uncorrectable, 0);
    chk("clr_c", "fue_v", first_ue_valid, 0);
    chk("clr_c", "fue_s", first_ue_syndrome, 0);

    clr_xfer(BASE ^ E_U1);
    chk("clr_u", "cnt_c", cnt_corrected, 0);
    chk("clr_u", "cnt_u", cnt_uncorrectable, 1);
    chk("clr_u", "fue_v", first_ue_valid, 1);
    chk("clr_u", "fue_s", first_ue_syndrome, 16'h8003);

    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_cw     = BASE ^ E_D1;
    @(negedge clk);
    in_cw = BASE ^ E_U2;
    @(negedge clk);
    in_valid = 1'b0;
    in_cw    = 'x;
    chk("mrst", "full_valid", out_valid, 1);
    chk("mrst", "full_ready", in_ready, 0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mrst", "out_valid", out_valid, 0);
    chk("mrst", "cnt_c", cnt_corrected, 0);
    chk("mrst", "cnt_u", cnt_uncorrectable, 0);
    chk("mrst", "fue_v", first_ue_valid, 0);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("mrst", "idle_valid", out_valid, 0);
    push1("post", BASE, 32'h8765_4321, 0, 0, 16'h0000);
    chk("post", "cnt_c", cnt_corrected, 0);
    chk("post", "cnt_u", cnt_uncorrectable, 0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
